// File: rtl/pc_fetch_pkg.sv
// Shared fetch/decode types: stall bus encoding, redirect and IF->ID bus layouts, FSM states.
// Pure declarations; no latency and no backpressure of its own.
package pc_fetch_pkg;

    localparam int          STALL_W      = 6;
    localparam int          IF_TO_ID_WD  = 33;
    localparam int          BR_WD        = 33;
    localparam logic [31:0] RESET_PC_DEF = 32'hBFC0_0000;

    localparam logic Stop   = 1'b1;
    localparam logic NoStop = 1'b0;

    typedef logic [STALL_W-1:0] stall_bus_t;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic        br_e;
        logic [31:0] br_addr;
    } br_bus_t;

    typedef struct packed {
        logic        ce;
        logic [31:0] pc;
    } if_to_id_t;

endpackage

// File: rtl/pc_fetch_if.sv
// Fetch-side outputs: IF->ID bus plus instruction SRAM request port.
// Combinational view of fetch registers; the SRAM answers one cycle later, no backpressure.
interface pc_fetch_if;
    import pc_fetch_pkg::*;

    if_to_id_t   if_to_id_bus;
    logic        inst_sram_en;
    logic [3:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [31:0] inst_sram_wdata;

    modport master (
        output if_to_id_bus,
        output inst_sram_en,
        output inst_sram_wen,
        output inst_sram_addr,
        output inst_sram_wdata
    );

    modport slave (
        input if_to_id_bus,
        input inst_sram_en,
        input inst_sram_wen,
        input inst_sram_addr,
        input inst_sram_wdata
    );
endinterface

// File: rtl/pc_fetch.sv
// PC register + instruction SRAM driver; redirect reaches inst_sram_addr 1 cycle after unstalled br_e.
// stall[0]==Stop freezes pc/ce and latches redirects; PC_ALIGN_CHECK_EN enables misaligned-fetch gating.
module pc_fetch
    import pc_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  stall_bus_t       stall,
    input  logic [BR_WD-1:0] br_bus,
    pc_fetch_if.master       fetch,
    output logic             if_adel,
    output logic [CNT_W-1:0] fetch_cnt
);

    fetch_state_e     state_q, state_d;
    logic [31:0]      pc_q, pc_d;
    logic             ce_q, ce_d;
    logic             pend_v_q, pend_v_d;
    logic [31:0]      pend_addr_q, pend_addr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             adel;
    logic             ce_out;
    logic             stop;
    br_bus_t          br;

    assign br   = br_bus_t'(br_bus);
    assign stop = (stall[0] == Stop);

    wire unused_stall_hi = ^stall[STALL_W-1:1];

`ifdef PC_ALIGN_CHECK_EN
    logic adel_q, adel_d;
    assign adel   = adel_q;
    assign adel_d = ce_d & (pc_d[1:0] != 2'b00);
`else
    assign adel = 1'b0;
`endif

    assign ce_out = ce_q & ~adel;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ce_d        = ce_q;
        pend_v_d    = pend_v_q;
        pend_addr_d = pend_addr_q;
        cnt_d       = cnt_q;
        if (state_q == BOOT) begin
            state_d = RUN;
            pc_d    = RESET_PC;
            ce_d    = 1'b1;
        end else if (!stop) begin
            if (ce_out) cnt_d = cnt_q + CNT_W'(1);
            if (br.br_e) begin
                pc_d     = br.br_addr;
                pend_v_d = 1'b0;
            end else if (pend_v_q) begin
                pc_d     = pend_addr_q;
                pend_v_d = 1'b0;
            end else if (!adel) begin
                // A misaligned pc parks here until decode redirects it.
                pc_d = pc_q + 32'd4;
            end
        end else if (br.br_e) begin
            pend_v_d    = 1'b1;
            pend_addr_d = br.br_addr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC - 32'd4;
            ce_q        <= 1'b0;
            pend_v_q    <= 1'b0;
            pend_addr_q <= 32'd0;
            cnt_q       <= '0;
`ifdef PC_ALIGN_CHECK_EN
            adel_q      <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ce_q        <= ce_d;
            pend_v_q    <= pend_v_d;
            pend_addr_q <= pend_addr_d;
            cnt_q       <= cnt_d;
`ifdef PC_ALIGN_CHECK_EN
            adel_q      <= adel_d;
`endif
        end
    end

    assign fetch.if_to_id_bus    = '{ce: ce_out, pc: pc_q};
    assign fetch.inst_sram_en    = ce_out;
    assign fetch.inst_sram_wen   = 4'b0000;
    assign fetch.inst_sram_addr  = pc_q;
    assign fetch.inst_sram_wdata = 32'd0;
    assign if_adel               = adel;
    assign fetch_cnt             = cnt_q;

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: stimulus pushes expected post-edge state, a negedge monitor pops and compares.
module tb_pc_fetch;
    import pc_fetch_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    stall_bus_t  stall = '0;
    logic [32:0] br_bus = '0;
    logic        if_adel;
    logic [31:0] fetch_cnt;

    pc_fetch_if fif ();

    pc_fetch dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .br_bus    (br_bus),
        .fetch     (fif),
        .if_adel   (if_adel),
        .fetch_cnt (fetch_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic        ce;
        logic [31:0] pc;
        logic        adel;
        logic        cnt_chk;
        logic [31:0] cnt;
    } exp_t;

    exp_t q[$];
    int   edge_cnt = 0;
    int   n_chk = 0;
    int   n_err = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (q.size() > 0 && q[0].cyc <= edge_cnt) begin
                e = q.pop_front();
                chk("ce",   32'(fif.if_to_id_bus.ce), 32'(e.ce));
                chk("en",   32'(fif.inst_sram_en),    32'(e.ce));
                chk("pc",   fif.if_to_id_bus.pc,      e.pc);
                chk("addr", fif.inst_sram_addr,       e.pc);
                chk("adel", 32'(if_adel),             32'(e.adel));
                if (e.cnt_chk) chk("cnt", fetch_cnt, e.cnt);
            end
        end
    end

    task automatic push(input int cyc, input logic ce, input logic [31:0] pc,
                        input logic adel, input logic cc, input logic [31:0] cnt);
        exp_t e;
        e.cyc = cyc; e.ce = ce; e.pc = pc; e.adel = adel; e.cnt_chk = cc; e.cnt = cnt;
        q.push_back(e);
    endtask

    // Called just after a posedge: drive inputs, expect the state after the next edge.
    task automatic step(input logic st, input logic be, input logic [31:0] ba,
                        input logic ece, input logic [31:0] epc, input logic eadel,
                        input logic cc, input logic [31:0] ecnt);
        stall[0] = st ? Stop : NoStop;
        br_bus   = {be, ba};
        push(edge_cnt + 1, ece, epc, eadel, cc, ecnt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset state while rst held low
        #1;
        push(edge_cnt, 1'b0, 32'hBFBF_FFFC, 1'b0, 1'b1, 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;

        // boot and sequential fetch
        step(0, 0, 0, 1, 32'hBFC0_0000, 0, 1, 0);
        step(0, 0, 0, 1, 32'hBFC0_0004, 0, 1, 1);
        step(0, 0, 0, 1, 32'hBFC0_0008, 0, 1, 2);
        step(0, 0, 0, 1, 32'hBFC0_000C, 0, 1, 3);
        step(0, 0, 0, 1, 32'hBFC0_0010, 0, 1, 4);
        // unstalled redirect
        step(0, 1, 32'h8000_1000, 1, 32'h8000_1000, 0, 1, 5);
        step(0, 0, 0,             1, 32'h8000_1004, 0, 1, 6);
        // redirect latched during a 3-cycle stall
        step(1, 1, 32'h8000_2000, 1, 32'h8000_1004, 0, 1, 6);
        step(1, 0, 0,             1, 32'h8000_1004, 0, 1, 6);
        step(1, 0, 0,             1, 32'h8000_1004, 0, 1, 6);
        step(0, 0, 0,             1, 32'h8000_2000, 0, 1, 7);
        step(0, 0, 0,             1, 32'h8000_2004, 0, 1, 8);
        // live br_e on release beats the pending target
        step(1, 1, 32'h8000_3500, 1, 32'h8000_2004, 0, 1, 8);
        step(1, 0, 0,             1, 32'h8000_2004, 0, 1, 8);
        step(0, 1, 32'h8000_3000, 1, 32'h8000_3000, 0, 1, 9);
        step(0, 0, 0,             1, 32'h8000_3004, 0, 1, 10);
        // pc wrap
        step(0, 1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFFC, 0, 1, 11);
        step(0, 0, 0,             1, 32'h0000_0000, 0, 1, 12);
        step(0, 0, 0,             1, 32'h0000_0004, 0, 1, 13);
        // second redirect in one stall overwrites the first
        step(1, 1, 32'h8000_4000, 1, 32'h0000_0004, 0, 1, 13);
        step(1, 1, 32'h8000_5000, 1, 32'h0000_0004, 0, 1, 13);
        step(0, 0, 0,             1, 32'h8000_5000, 0, 1, 14);
        step(0, 0, 0,             1, 32'h8000_5004, 0, 1, 15);
        // async reset mid-stall with a pending redirect
        step(1, 1, 32'h8000_6000, 1, 32'h8000_5004, 0, 1, 15);
        stall[0] = Stop;
        br_bus   = '0;
        @(negedge clk); #1;
        rst = 1'b0;
        push(edge_cnt, 1'b0, 32'hBFBF_FFFC, 1'b0, 1'b1, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        step(0, 0, 0, 1, 32'hBFC0_0000, 0, 1, 0);
        step(0, 0, 0, 1, 32'hBFC0_0004, 0, 1, 1);
`ifdef PC_ALIGN_CHECK_EN
        step(0, 1, 32'h8000_0002, 0, 32'h8000_0002, 1, 0, 0);
        step(0, 0, 0,             0, 32'h8000_0002, 1, 0, 0);
        step(0, 1, 32'h8000_0100, 1, 32'h8000_0100, 0, 0, 0);
        step(0, 0, 0,             1, 32'h8000_0104, 0, 0, 0);
`endif

        for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
        #1;
        if (q.size() > 0) begin
            n_chk++;
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        chk("wen",   32'(fif.inst_sram_wen), 32'd0);
        chk("wdata", fif.inst_sram_wdata,    32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
